// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the MIPS MEM stage to a word-wide data memory. Byte and halfword
//   loads are extracted from the read word and then sign- or zero-extended.
//   Partial stores are done as read-modify-write. Byte lanes are big-endian.
//
//   Optional build macro: ALIGN_CHECK_EN
//     defined   : a misaligned halfword or word access is not performed.
//                 It completes in one cycle with err_o=1.
//     undefined : err_o stays 0. The low address bits are ignored and the
//                 access goes ahead on the aligned address.
//
//   Ports
//     clk, rst          clock; synchronous active-high reset
//     req_i             request, sampled only while ready_o=1
//     we_i              1=store, 0=load
//     size_i            00 byte, 01 halfword, 10/11 word
//     sext_i            sign-extend loads
//     addr_i, data_i    byte address; store data, right-justified
//     ready_o           idle and able to accept a request
//     done_o, err_o     one-cycle completion pulse; misalignment flag
//     data_o            load result, held until the next load completes
//     mem_addr_o        word-aligned byte address to memory
//     mem_cs_o          read select; the word is returned one cycle later
//     mem_we_o          write enable (issued with mem_cs_o=0)
//     mem_data_o        write word
//     mem_data_i        read word
module load_store_unit #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [1:0]       size_i,
  input  logic             sext_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic             mem_cs_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_data_o,
  input  logic [WIDTH-1:0] mem_data_i
);

  // The lane logic is hard-wired for four bytes. SIZE describes only the
  // attached memory, so neither parameter adds any logic here.
  if (WIDTH != 32 || SIZE < 1) begin : g_unsupported_cfg
  end

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] buf_reg;      // word buffer: read word, merged word or store word
  logic [WIDTH-1:0] data_o_reg;
  logic [15:0]      sdata_reg;    // only the low halfword is ever merged
  logic [1:0]       size_reg;
  logic             we_reg;
  logic             sext_reg;
  logic             done_reg;
  logic             err_reg;

  logic             req_misaligned;
  logic             is_byte;
  logic             is_half;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] merged;

`ifdef ALIGN_CHECK_EN
  assign req_misaligned = ((size_i == 2'b01) && addr_i[0]) ||
                          (size_i[1] && (addr_i[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  // Size 11 decodes as neither byte nor halfword, so it is treated as a word.
  assign is_byte = (size_reg == 2'b00);
  assign is_half = (size_reg == 2'b01);

  // Load lane extraction: byte offset 0 is the most significant byte.
  always_comb begin
    byte_lane = 8'h00;
    case (addr_reg[1:0])
      2'd0: byte_lane = mem_data_i[31:24];
      2'd1: byte_lane = mem_data_i[23:16];
      2'd2: byte_lane = mem_data_i[15:8];
      default: byte_lane = mem_data_i[7:0];
    endcase
    half_lane = addr_reg[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    if (is_byte)
      load_word = {{24{sext_reg & byte_lane[7]}}, byte_lane};
    else if (is_half)
      load_word = {{16{sext_reg & half_lane[15]}}, half_lane};
    else
      load_word = mem_data_i;
  end

  // Store merge. Lane gi holds bits [31-8*gi -: 8]. A selected lane takes the
  // store byte and every other lane keeps the word read from memory. For a
  // halfword, the even lane of the pair gets the upper store byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       lane_sel;
    logic [7:0] lane_src;
    assign lane_sel = is_byte ? (addr_reg[1:0] == 2'(gi))
                              : (is_half && (addr_reg[1] == 1'(gi / 2)));
    assign lane_src = is_byte ? sdata_reg[7:0] : sdata_reg[8*(1 - gi % 2) +: 8];
    assign merged[31-8*gi -: 8] = lane_sel ? lane_src : mem_data_i[31-8*gi -: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      buf_reg    <= '0;
      data_o_reg <= '0;
      sdata_reg  <= '0;
      size_reg   <= 2'b00;
      we_reg     <= 1'b0;
      sext_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_i) begin
            addr_reg  <= addr_i;
            size_reg  <= size_i;
            we_reg    <= we_i;
            sext_reg  <= sext_i;
            sdata_reg <= data_i[15:0];
            buf_reg   <= data_i;     // a word store writes this unchanged
            if (req_misaligned) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end else if (!we_i || !size_i[1]) begin
              state_reg <= RD;
            end else begin
              state_reg <= WR;
            end
          end
        end
        RD: state_reg <= CAP;
        CAP: begin
          buf_reg <= merged;
          if (we_reg) begin
            state_reg <= WR;
          end else begin
            data_o_reg <= load_word;
            state_reg  <= DONE;
            done_reg   <= 1'b1;
          end
        end
        WR: begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst so that a reset edge never touches memory,
  // not even one that lands in the WR cycle.
  assign ready_o    = (state_reg == IDLE) && !rst;
  assign mem_cs_o   = (state_reg == RD) && !rst;
  assign mem_we_o   = (state_reg == WR) && !rst;
  assign mem_addr_o = {addr_reg[WIDTH-1:2], 2'b00};
  assign mem_data_o = buf_reg;
  assign done_o     = done_reg;
  assign err_o      = err_reg;
  assign data_o     = data_o_reg;

endmodule
